// File: rtl/sfp_vec_mul_s_seq.sv
// Sequential 3-element vector times scalar in signed fixed point Q(IW).(QW).
// One shared multiplier handles one component per cycle; results saturate on overflow.
module sfp_vec_mul_s_seq #(
  parameter int IW = 16,
  parameter int QW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IW+QW-1:0]     a [3],
  input  logic [IW+QW-1:0]     s,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IW+QW-1:0]     o [3],
  output logic [1:0]           dbg_state
);
  localparam int W = IW + QW;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never drops and its payload never changes until that transfer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]          a_q [3];
  logic [W-1:0]          s_q;
  logic [1:0]            k;
  logic signed [W-1:0]   mul_a;
  logic signed [W-1:0]   mul_b;
  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] shifted;
  logic                  ovf_pos;
  logic                  ovf_neg;
  logic [W-1:0]          res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = MUL;
      MUL:     if (k == 2'd2) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    dbg_state = state;
  end

  // Shared multiplier: operand select by component index.
  always_comb begin
    case (k)
      2'd0:    mul_a = $signed(a_q[0]);
      2'd1:    mul_a = $signed(a_q[1]);
      default: mul_a = $signed(a_q[2]);
    endcase
    mul_b = $signed(s_q);
  end

  // Arithmetic shift floors toward minus infinity; overflow exists when the bits
  // above the result's sign bit are not a pure sign extension.
  always_comb begin
    prod    = mul_a * mul_b;
    shifted = prod >>> QW;
    ovf_pos = !shifted[2*W-1] && (|shifted[2*W-2:W-1]);
    ovf_neg = shifted[2*W-1] && !(&shifted[2*W-2:W-1]);
    if (ovf_pos) begin
      res = {1'b0, {(W-1){1'b1}}};
    end else if (ovf_neg) begin
      res = {1'b1, {(W-1){1'b0}}};
    end else begin
      res = shifted[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k   <= 2'd0;
      s_q <= '0;
      for (int i = 0; i < 3; i++) begin
        a_q[i] <= '0;
        o[i]   <= '0;
      end
    end else begin
      if (state == IDLE && in_valid) begin
        s_q <= s;
        k   <= 2'd0;
        for (int i = 0; i < 3; i++) begin
          a_q[i] <= a[i];
        end
      end
      if (state == MUL) begin
        k <= k + 2'd1;
        for (int i = 0; i < 3; i++) begin
          if (k == 2'(i)) o[i] <= res;
        end
      end
    end
  end
endmodule

// File: tb/tb_sfp_vec_mul_s_seq.sv
// Bench for sfp_vec_mul_s_seq: directed vectors plus a random stream, checked by a
// queue-based scoreboard in an independent monitor process.
module tb_sfp_vec_mul_s_seq;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a [3];
  logic [W-1:0]  s = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  o [3];
  logic [1:0]    dbg_state;

  logic [3*W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  logic           prev_hold = 1'b0;
  logic [3*W-1:0] prev_o = '0;
  logic           rand_ready_en = 1'b0;

  sfp_vec_mul_s_seq #(.IW(16), .QW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .s(s),
    .out_valid(out_valid), .out_ready(out_ready), .o(o), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    a[0] = '0; a[1] = '0; a[2] = '0;
  end

  task automatic check(input string name, input logic [3*W-1:0] act, input logic [3*W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    p = p >>> 16;
    if (p > 64'sd2147483647) return 32'h7FFFFFFF;
    if (p < -64'sd2147483648) return 32'h80000000;
    return p[31:0];
  endfunction

  function automatic logic [3*W-1:0] cur_o();
    return {o[0], o[1], o[2]};
  endfunction

  // driver: present a vector until it is accepted, then scramble the operands
  task automatic send(input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] a2,
                      input logic [W-1:0] s0, input logic [3*W-1:0] e);
    int t;
    t = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; a[0] = a0; a[1] = a1; a[2] = a2; s = s0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) break;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready stuck at %b, expected 1", in_ready);
      @(posedge clk); #1; in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a[0] = $urandom; a[1] = $urandom; a[2] = $urandom; s = $urandom;
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1; out_ready = v;
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk); t++;
    end
    check("drain_empty", 96'(exp_q.size()), 96'd0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [3*W-1:0] e;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 96'(out_valid), 96'd1);
        check("hold_o", cur_o(), prev_o);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got %h expected none", cur_o());
        end else begin
          e = exp_q.pop_front();
          check("result", cur_o(), e);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_o = cur_o();
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    logic [W-1:0] ra [3];
    logic [W-1:0] rs;
    int t;

    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 96'(out_valid), 96'd0);
    check("rst_in_ready", 96'(in_ready), 96'd1);
    check("rst_o", cur_o(), 96'd0);
    check("rst_state", 96'(dbg_state), 96'd0);

    // basic vector with latency check
    send(32'h00010000, 32'h00020000, 32'hFFFD0000, 32'h00008000,
         {32'h00008000, 32'h00010000, 32'hFFFE8000});
    @(negedge clk); check("lat_n0", 96'(out_valid), 96'd0);
    @(negedge clk); check("lat_n1", 96'(out_valid), 96'd0);
    @(negedge clk); check("lat_n2", 96'(out_valid), 96'd0);
    @(negedge clk); check("lat_n3", 96'(out_valid), 96'd1);
    drain(20);

    // saturation both directions
    send(32'h7FFF0000, 32'h80010000, 32'h00000000, 32'h00020000,
         {32'h7FFFFFFF, 32'h80000000, 32'h00000000});
    // floor rule
    send(32'h00000001, 32'hFFFFFFFF, 32'h00010000, 32'h00008000,
         {32'h00000000, 32'hFFFFFFFF, 32'h00008000});
    drain(20);

    // backpressure in DONE with a competing input
    set_ready(1'b0);
    send(32'h00030000, 32'hFFFF0000, 32'h00004000, 32'h00020000,
         {32'h00060000, 32'hFFFE0000, 32'h00008000});
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    check("bp_reach_done", 96'(out_valid), 96'd1);
    @(posedge clk); #1;
    in_valid = 1'b1; a[0] = 32'h00050000; a[1] = 32'h00010000; a[2] = 32'h00000000; s = 32'hFFFF0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 96'(out_valid), 96'd1);
      check("bp_in_ready", 96'(in_ready), 96'd0);
      check("bp_o", cur_o(), {32'h00060000, 32'hFFFE0000, 32'h00008000});
    end
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
    send(32'h00050000, 32'h00010000, 32'h00000000, 32'hFFFF0000,
         {32'hFFFB0000, 32'hFFFF0000, 32'h00000000});
    drain(20);

    // reset in the second MUL cycle aborts the operation
    send(32'h00040000, 32'h00040000, 32'h00040000, 32'h00010000,
         {32'h00040000, 32'h00040000, 32'h00040000});
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("abort_out_valid", 96'(out_valid), 96'd0);
    check("abort_in_ready", 96'(in_ready), 96'd1);
    check("abort_o", cur_o(), 96'd0);
    send(32'h00010000, 32'h00020000, 32'hFFFD0000, 32'h00008000,
         {32'h00008000, 32'h00010000, 32'hFFFE8000});
    drain(20);

    // random stream with random gaps and random out_ready
    rand_ready_en = 1'b1;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 3; i++) begin
        case ($urandom_range(0, 2))
          0:       ra[i] = $urandom;
          1:       ra[i] = 32'($signed(16'($urandom))) <<< 4;
          default: ra[i] = 32'($signed(24'($urandom)));
        endcase
      end
      rs = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(20'($urandom)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(ra[0], ra[1], ra[2], rs, {ref_mul(ra[0], rs), ref_mul(ra[1], rs), ref_mul(ra[2], rs)});
    end
    drain(500);
    rand_ready_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sfp_vec_mul_s_seq.md
SFP_VEC_MUL_S_SEQ -- requirements
Module: sfp_vec_mul_s_seq

Interface
REQ-001 Parameter IW, default 16, meaning integer bits of the signed fixed-point format.
REQ-002 Parameter QW, default 16, meaning fraction bits; word width W = IW+QW = 32.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  input vector and scalar are valid.
REQ-006 in_ready  output  1  block can accept an input this cycle.
REQ-007 a  input  W x 3 (unpacked array [3])  vector operand, two's-complement Q(IW).(QW).
REQ-008 s  input  W  scalar operand, same format.
REQ-009 out_valid  output  1  o holds a completed result.
REQ-010 out_ready  input  1  downstream (vector add-scalar stage) accepts o.
REQ-011 o  output  W x 3 (unpacked array [3])  result o[i] = a[i]*s.

Function
REQ-012 The block SHALL compute o[i] = sat(floor(a[i]*s / 2^QW)) for i = 0..2 using exactly one shared W x W signed multiplier.
REQ-013 The full 2W-bit signed product SHALL be arithmetically shifted right by QW (truncation toward minus infinity, no rounding).
REQ-014 If the shifted product exceeds 2^(W-1)-1, the result SHALL be 0x7FFFFFFF; if below -2^(W-1), 0x80000000.
REQ-015 FSM states SHALL be IDLE, MUL, DONE.
REQ-016 IDLE: in_ready=1; on in_valid the block SHALL latch a[0..2] and s, clear component index k to 0, and go to MUL.
REQ-017 MUL: in_ready=0; each cycle the block SHALL compute component k, write o[k], increment k; after k=2 it SHALL go to DONE.
REQ-018 DONE: out_valid=1, in_ready=0; o SHALL stay stable until out_ready=1, then the block SHALL go to IDLE.
REQ-019 Latency: input accepted on edge N SHALL give out_valid=1 from the cycle after edge N+3 (3 MUL cycles).
REQ-020 Throughput: one vector per 5 cycles with out_ready held high; no acceptance while MUL or DONE.
REQ-021 Operand changes on a/s after acceptance SHALL NOT affect the in-flight result.
REQ-022 in_valid asserted while in_ready=0 SHALL be ignored; the input is not consumed.
REQ-023 o SHALL hold its last value in IDLE and MUL until overwritten component by component; consumers SHALL use o only when out_valid=1.
REQ-024 out_valid SHALL never drop without a handshake (out_valid & out_ready).

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, k=0, o[0..2]=0, latched operands=0.
REQ-026 Reset outputs: out_valid=0, in_ready=1 in the first cycle after reset.
REQ-027 Reset asserted in MUL or DONE SHALL abort the operation; no out_valid for the aborted input.
REQ-028 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-029 a={0x00010000,0x00020000,0xFFFD0000}, s=0x00008000, out_ready=1 -> o={0x00008000,0x00010000,0xFFFE8000}, out_valid 4 cycles after acceptance.
REQ-030 a={0x7FFF0000,0x80010000,0}, s=0x00020000 -> o={0x7FFFFFFF,0x80000000,0x00000000}.
REQ-031 a={0x00000001,0xFFFFFFFF,0x00010000}, s=0x00008000 -> o={0x00000000,0xFFFFFFFF,0x00008000} (floor rule).
REQ-032 out_ready=0 for 10 cycles in DONE, in_valid=1 with new operands -> o and out_valid unchanged, in_ready=0, new input accepted only after the handshake.
REQ-033 rst pulsed in the 2nd MUL cycle -> next cycle out_valid=0, in_ready=1, o={0,0,0}; next input produces a correct result.
REQ-034 Back-to-back random stream, in_valid and out_ready randomly toggled -> every accepted vector produced once, in order, matching the saturating floor reference model.
